// File: rtl/mux8_arb_pkg.sv
// rtl/mux8_arb_pkg.sv - shared types, widths and rotating-priority pick for the 8:1 mux arbiter
package mux8_arb_pkg;

  localparam int NREQ   = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 4;

  typedef enum logic {IDLE, GRANT} state_e;

  // Returns {found, index}: first set bit of mask searching ptr+1, ptr+2, ... with ptr itself last.
  function automatic logic [SEL_W:0] rr_pick(input logic [NREQ-1:0] mask,
                                             input logic [SEL_W-1:0] ptr);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = ptr + SEL_W'(i);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/mux8_sel.sv
// rtl/mux8_sel.sv - gated 8:1 single-bit select of din by sel
module mux8_sel
  import mux8_arb_pkg::*;
(
  input  logic [NREQ-1:0]  din,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_valid,
  output logic             y
);

  // Forced low without a grant so y never carries a stale or unknown bit.
  assign y = sel_valid & din[sel];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin 8-way arbiter driving the mux select; burst limit via MUX8_ARB_BURST_LIMIT_EN
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  din,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             y
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [SEL_W:0]   pick_all, pick_oth;
  logic [NREQ-1:0]  others;
  logic             owner_req, force_rot;

  assign others    = req & ~gnt_q;
  assign owner_req = req[sel_q];
  assign pick_all  = rr_pick(req, ptr_q);
  // ptr_q holds the owner while granted, so this search naturally starts just past it.
  assign pick_oth  = rr_pick(others, ptr_q);

`ifdef MUX8_ARB_BURST_LIMIT_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // hold_cnt counts held edges, so the current cycle is granted cycle hold_cnt+1.
  assign force_rot = (|others) &&
                     (({1'b0, hold_cnt_q} + (HOLD_W+1)'(1)) >= (HOLD_W+1)'(HOLD_MAX));
`else
  assign force_rot = 1'b0;
  if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_hold_max_out_of_range
  end
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
`ifdef MUX8_ARB_BURST_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_all[SEL_W]) begin
          state_d = GRANT;
          ptr_d   = pick_all[SEL_W-1:0];
          sel_d   = pick_all[SEL_W-1:0];
          gnt_d   = NREQ'(1) << pick_all[SEL_W-1:0];
          valid_d = 1'b1;
`ifdef MUX8_ARB_BURST_LIMIT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        if (owner_req && !force_rot) begin
`ifdef MUX8_ARB_BURST_LIMIT_EN
          if (hold_cnt_q != HOLD_W'(HOLD_MAX)) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
        end else if (pick_oth[SEL_W]) begin
          ptr_d   = pick_oth[SEL_W-1:0];
          sel_d   = pick_oth[SEL_W-1:0];
          gnt_d   = NREQ'(1) << pick_oth[SEL_W-1:0];
`ifdef MUX8_ARB_BURST_LIMIT_EN
          hold_cnt_d = '0;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          sel_d   = '0;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= SEL_W'(NREQ - 1);
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
`ifdef MUX8_ARB_BURST_LIMIT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
`ifdef MUX8_ARB_BURST_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign sel_valid = valid_q;

  mux8_sel u_sel (
    .din       (din),
    .sel       (sel_q),
    .sel_valid (valid_q),
    .y         (y)
  );

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - scoreboard bench for mux8_rr_arbiter against an owner/last/run-length model
module tb_mux8_rr_arbiter;

  localparam int HOLD_MAX = 4;
`ifdef MUX8_ARB_BURST_LIMIT_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       v;
    logic       y;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] din = '0;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       sel_valid;
  logic       y;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  int m_owner;
  int m_last;
  int m_run;

  mux8_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .sel       (sel),
    .sel_valid (sel_valid),
    .y         (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int first_after(input logic [7:0] mask, input int from);
    for (int k = 1; k <= 8; k++) begin
      if (mask[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  // Called at a negedge: apply inputs, advance the model by one edge, queue the result, move to the next negedge.
  task automatic drive(input logic [7:0] r, input logic [7:0] d);
    exp_t e;
    logic [7:0] oth;
    int nxt;
    req = r;
    din = d;
    if (m_owner < 0) begin
      nxt = first_after(r, m_last);
      if (nxt >= 0) begin
        m_owner = nxt;
        m_last  = nxt;
        m_run   = 1;
      end
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (r[m_owner] && !(BURST && m_run >= HOLD_MAX && oth != 0)) begin
        m_run++;
      end else if (oth != 0) begin
        m_owner = first_after(oth, m_owner);
        m_last  = m_owner;
        m_run   = 1;
      end else begin
        m_owner = -1;
      end
    end
    e.v   = (m_owner >= 0);
    e.gnt = e.v ? (8'h01 << m_owner) : 8'h00;
    e.sel = e.v ? 3'(m_owner) : 3'd0;
    e.y   = e.v ? d[m_owner] : 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Called at a negedge; asserts reset between edges and checks outputs clear before any edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    req   = 8'hFF;
    #1;
    check("rst_gnt", gnt, 8'h00);
    check("rst_sel", {5'd0, sel}, 8'h00);
    check("rst_valid", {7'd0, sel_valid}, 8'h00);
    check("rst_y", {7'd0, y}, 8'h00);
    m_owner = -1;
    m_last  = 7;
    m_run   = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt", gnt, e.gnt);
        check("sel", {5'd0, sel}, {5'd0, e.sel});
        check("sel_valid", {7'd0, sel_valid}, {7'd0, e.v});
        check("y", {7'd0, y}, {7'd0, e.y});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [7:0] r;
    @(negedge clk);
    do_reset();
    drive(8'hFF, 8'h00);

    do_reset();
    drive(8'h85, 8'h5A);
    drive(8'h84, 8'h5A);
    drive(8'h81, 8'h5A);
    drive(8'h05, 8'h5A);
    drive(8'h05, 8'h5A);

    drive(8'h00, 8'h00);
    drive(8'h40, 8'h40);
    drive(8'h41, 8'h40);
    drive(8'h01, 8'h01);
    drive(8'h00, 8'h01);

    for (int k = 0; k < 8; k++) drive(8'h01 << k, 8'hCB);
    drive(8'h00, 8'hCB);

    for (int k = 0; k < 20; k++) drive(8'h03, 8'($urandom));
    for (int k = 0; k < 10; k++) drive(8'h01, 8'($urandom));

    drive(8'h00, 8'h00);
    drive(8'h08, 8'hFF);
    drive(8'h08, 8'hFF);
    do_reset();
    drive(8'h08, 8'h08);

    r = 8'h00;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(7))
        0:       r = 8'($urandom);
        1:       r = 8'h00;
        2:       r[$urandom_range(7)] = ~r[$urandom_range(7)];
        3:       r = r & ~(8'h01 << sel);
        default: ;
      endcase
      drive(r, 8'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
